// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: control inputs and audio/status outputs of the melody sequencer.
interface melody_sequencer_if;
   logic       start;
   logic       stop;
   logic       loop;
   logic       out;
   logic       busy;
   logic [2:0] note_code;
   logic       done;
   modport master (output start, stop, loop, input out, busy, note_code, done);
   modport slave  (input start, stop, loop, output out, busy, note_code, done);
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed 16-entry ROM melody as a square wave on one pin,
// choosing pitch and duration per step under start/stop/loop control.
module melody_sequencer #(
   parameter int unsigned CLOCK_FREQUENCY = 50000000,
   parameter int unsigned TICK_CYCLES     = 5000000
) (
   input  logic              clock,
   input  logic              reset,
   melody_sequencer_if.slave bus
);
   localparam int     TONE_W  = 20;
   localparam longint DUR_MAX = 15 * longint'(TICK_CYCLES);
   localparam int     DUR_W   = $clog2(DUR_MAX + 1);

   function automatic longint half_of(input logic [2:0] n);
      longint f;
      case (n)
         3'd1:    f = 26163;
         3'd2:    f = 29366;
         3'd3:    f = 32963;
         3'd4:    f = 34923;
         3'd5:    f = 39200;
         3'd6:    f = 44000;
         3'd7:    f = 49388;
         default: f = 0;
      endcase
      return (f == 0) ? 0 : longint'(CLOCK_FREQUENCY) * 50 / f;
   endfunction

   for (genvar g = 1; g < 8; g++) begin : g_chk
      if (half_of(3'(g)) < 1 || half_of(3'(g)) >= (longint'(1) << TONE_W)) begin : g_bad
         $error("melody_sequencer: half-period of note %0d does not fit the tone counter", g);
      end
   end

   // entries are {note[2:0], dur[3:0]}; dur == 0 marks the end of the melody
   function automatic logic [6:0] rom(input logic [3:0] i);
      case (i)
         4'd0:    return {3'd1, 4'd2};
         4'd1:    return {3'd3, 4'd2};
         4'd2:    return {3'd5, 4'd2};
         4'd3:    return {3'd0, 4'd1};
         4'd4:    return {3'd5, 4'd1};
         4'd5:    return {3'd3, 4'd1};
         4'd6:    return {3'd1, 4'd4};
         default: return 7'd0;
      endcase
   endfunction

   typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

   state_t            state_q;
   logic [3:0]        idx_q;
   logic [DUR_W-1:0]  dur_q;
   logic [TONE_W-1:0] tone_q;
   logic [2:0]        note_q;
   logic              out_q;
   logic              busy_q;
   logic              done_q;
   logic [6:0]        ent;
   logic [TONE_W-1:0] half;

   assign ent  = rom(idx_q);
   assign half = TONE_W'(half_of(note_q));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         dur_q   <= '0;
         tone_q  <= '0;
         note_q  <= '0;
         out_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q != IDLE && bus.stop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            idx_q   <= '0;
            note_q  <= '0;
            out_q   <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (bus.start) begin
                  state_q <= LOAD;
                  busy_q  <= 1'b1;
               end
               LOAD: if (ent[3:0] != 4'd0) begin
                  state_q <= PLAY;
                  dur_q   <= DUR_W'(ent[3:0]) * DUR_W'(TICK_CYCLES);
                  tone_q  <= '0;
                  out_q   <= 1'b0;
                  note_q  <= ent[6:4];
               end else if (bus.loop) begin
                  idx_q <= '0;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  idx_q   <= '0;
                  done_q  <= 1'b1;
               end
               PLAY: begin
                  dur_q <= dur_q - DUR_W'(1);
                  if (dur_q == DUR_W'(1)) begin
                     state_q <= LOAD;
                     idx_q   <= idx_q + 4'd1;
                     tone_q  <= '0;
                     out_q   <= 1'b0;
                     note_q  <= '0;
                  end else if (note_q != 3'd0) begin
                     out_q  <= (tone_q == half - TONE_W'(1)) ? ~out_q : out_q;
                     tone_q <= (tone_q == half - TONE_W'(1)) ? '0 : tone_q + TONE_W'(1);
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign bus.out       = out_q;
   assign bus.busy      = busy_q;
   assign bus.note_code = note_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: randomized start/stop/loop/reset stimulus; a cycle-level
// timeline model predicts every output cycle and a monitor checks it.
module tb_melody_sequencer;
   localparam int CF = 100000;
   localparam int TK = 1000;

   typedef struct packed {
      logic       out;
      logic       busy;
      logic [2:0] note;
      logic       done;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc_n = 0;
   obs_t exp_q[$];

   melody_sequencer_if bus ();

   melody_sequencer #(.CLOCK_FREQUENCY(CF), .TICK_CYCLES(TK)) dut (
      .clock(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int m_note[8] = '{1, 3, 5, 0, 5, 3, 1, 0};
   int m_dur [8] = '{2, 2, 2, 1, 1, 1, 4, 0};
   int m_freq[8] = '{0, 26163, 29366, 32963, 34923, 39200, 44000, 49388};

   function automatic int half(input int n);
      return CF * 50 / m_freq[n];
   endfunction

   // offset (cycles after the first LOAD) of the end-marker LOAD
   function automatic int last_off();
      int off = 0;
      for (int k = 0; k < 8 && m_dur[k] != 0; k++) off += 1 + m_dur[k] * TK;
      return off;
   endfunction

   function automatic obs_t expect_at(input bit act, input int t, input bit dn);
      obs_t e = '0;
      int   off = 0;
      e.done = dn;
      if (!act) return e;
      e.busy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (t == off || m_dur[k] == 0) return e;
         if (t < off + 1 + m_dur[k] * TK) begin
            e.note = 3'(m_note[k]);
            e.out  = (m_note[k] != 0) && (((t - off - 1) / half(m_note[k])) % 2 == 1);
            return e;
         end
         off += 1 + m_dur[k] * TK;
      end
      return e;
   endfunction

   // reference model: active flag + position in the melody timeline
   initial begin
      bit m_act = 1'b0;
      bit m_dn  = 1'b0;
      int m_t   = 0;
      int last  = last_off();
      forever begin
         @(posedge clk);
         if (rst) begin
            m_act = 1'b0;
            m_dn  = 1'b0;
            m_t   = 0;
         end else if (!m_act) begin
            m_dn = 1'b0;
            if (bus.start) begin
               m_act = 1'b1;
               m_t   = 0;
            end
         end else if (bus.stop) begin
            m_act = 1'b0;
         end else if (m_t == last) begin
            if (bus.loop) m_t = 0;
            else begin
               m_act = 1'b0;
               m_dn  = 1'b1;
            end
         end else begin
            m_t++;
         end
         exp_q.push_back(expect_at(m_act, m_t, m_dn));
      end
   end

   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.out, bus.busy, bus.note_code, bus.done};
            tests++;
            if (a !== e) begin
               fails++;
               $display("FAIL outputs t=%0t got out=%b busy=%b note=%0d done=%b want out=%b busy=%b note=%0d done=%b",
                        $time, a.out, a.busy, a.note, a.done, e.out, e.busy, e.note, e.done);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      cyc_n += n;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
   endtask

   initial begin
      int s;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.loop  = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(5);
      // full melody, loop=0, with ignored start pulses while busy
      pulse_start();
      s = cyc_n;
      cyc(499);
      pulse_start();
      repeat (3) begin
         cyc($urandom_range(50, 3000));
         pulse_start();
      end
      cyc(13019 - (cyc_n - s));
      cyc(10);
      // looping playback over two full passes, then stop
      bus.loop = 1'b1;
      pulse_start();
      cyc(2 * 13008 + 150);
      pulse_stop();
      bus.loop = 1'b0;
      cyc(10);
      // stop mid E4, then a fresh start
      pulse_start();
      cyc(2999);
      pulse_stop();
      cyc($urandom_range(5, 50));
      pulse_start();
      cyc($urandom_range(1500, 4000));
      pulse_stop();
      cyc(10);
      // stop sampled in the first LOAD and in a between-note LOAD
      pulse_start();
      pulse_stop();
      cyc(5);
      pulse_start();
      cyc(2001);
      pulse_stop();
      cyc(5);
      // asynchronous reset mid G4
      pulse_start();
      cyc($urandom_range(4100, 5900));
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({bus.out, bus.busy, bus.note_code} !== 5'b0) begin
         fails++;
         $display("FAIL async_reset got out=%b busy=%b note=%0d want 0 0 0", bus.out, bus.busy, bus.note_code);
      end
      cyc(2);
      rst = 1'b0;
      cyc(300);
      pulse_start();
      cyc(600);
      pulse_stop();
      cyc(5);
      // random sessions
      repeat (3) begin
         bus.loop = 1'($urandom_range(0, 1));
         pulse_start();
         cyc($urandom_range(200, 9000));
         pulse_stop();
         bus.loop = 1'b0;
         cyc($urandom_range(1, 20));
      end
      cyc(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
